// File: rtl/fetch_seq_pkg.sv
// Shared constants and state encoding for the ONC-16 fetch sequencer.
package fetch_seq_pkg;

    localparam int unsigned FS_STATE_W = 2;

    localparam int unsigned    ONC_PC_W      = 16;
    localparam int unsigned    ONC_INST_W    = 16;
    localparam logic [15:0]    ONC_RESET_VEC = 16'h0000;

    typedef enum logic [FS_STATE_W-1:0] {
        FsBoot  = 2'd0,
        FsFetch = 2'd1,
        FsExec  = 2'd2,
        FsHalt  = 2'd3
    } fs_state_e;

endpackage

// File: rtl/fetch_seq_pc_next.sv
// Combinational next-PC mux: hold, increment or branch, selected by {de, bre}.
// Also used by the debug single-step path, so it carries no state.
module fetch_seq_pc_next #(
    parameter int unsigned PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    input  logic            de,
    input  logic            bre,
    output logic [PC_W-1:0] pc_nxt
);

    // bre only counts while de is high; everything else holds the PC.
    always_comb begin
        pc_nxt = pc;
        unique case ({de, bre})
            2'b10:   pc_nxt = pc + PC_W'(1);
            2'b11:   pc_nxt = br_target;
            default: pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC register, imem request/ack handshake,
// instruction register and the one-cycle decode-enable pulse.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int unsigned     PC_W      = ONC_PC_W,
    parameter int unsigned     INST_W    = ONC_INST_W,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(ONC_RESET_VEC)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              bre,
    input  logic [PC_W-1:0]   br_target,
    input  logic              stall,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              de,
    output logic              halted
);

    fs_state_e         state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_out_q;
    logic              load_ir;

    fetch_seq_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc        (pc_q),
        .br_target (br_target),
        .de        (de),
        .bre       (bre),
        .pc_nxt    (pc_d)
    );

    // State, PC and instruction register; reset abandons any outstanding request.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= FsBoot;
            pc_q     <= RESET_VEC;
            inst_q   <= '0;
            pc_out_q <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (load_ir) begin
                inst_q   <= inst_in;
                pc_out_q <= pc_q;
            end
        end
    end

    // Next-state decode and Moore outputs; de is the only input-dependent output.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        de       = 1'b0;
        halted   = 1'b0;
        load_ir  = 1'b0;
        unique case (state_q)
            FsBoot: begin
                state_d = FsFetch;
            end
            FsFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_ir = 1'b1;
                    state_d = FsExec;
                end
            end
            FsExec: begin
                // A stall defers the branch decision rather than dropping it.
                de = !stall;
                if (de) begin
                    state_d = halt_req ? FsHalt : FsFetch;
                end
            end
            FsHalt: begin
                halted = 1'b1;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign inst_out  = inst_q;
    assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a cycle-by-cycle vector table plus hand-written
// sequences for the delayed ack, asynchronous reset and branch-with-halt cases.
module tb_fetch_seq;

    logic        clock = 1'b0;
    logic        rst;
    logic        bre;
    logic [15:0] br_target;
    logic        stall;
    logic        halt_req;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] inst_in;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        de;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_seq dut (
        .clock     (clock),
        .rst       (rst),
        .bre       (bre),
        .br_target (br_target),
        .stall     (stall),
        .halt_req  (halt_req),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .inst_in   (inst_in),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .de        (de),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic        bre;
        logic        halt_req;
        logic        ack;
        logic [15:0] inst;
        logic [15:0] tgt;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_de;
        logic        exp_halted;
        logic [15:0] exp_inst;
        logic [15:0] exp_pc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic b, input logic h, input logic a,
                                input logic [15:0] inst, input logic [15:0] tgt,
                                input logic req, input logic [15:0] addr, input logic d,
                                input logic hl, input logic [15:0] io, input logic [15:0] po);
        vec_t v;
        v.stall = s; v.bre = b; v.halt_req = h; v.ack = a;
        v.inst = inst; v.tgt = tgt;
        v.exp_req = req; v.exp_addr = addr; v.exp_de = d;
        v.exp_halted = hl; v.exp_inst = io; v.exp_pc = po;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                           input logic d, input logic hl, input logic [15:0] io,
                           input logic [15:0] po);
        chk({tag, ".imem_req"},  16'(imem_req), 16'(req));
        chk({tag, ".imem_addr"}, imem_addr, addr);
        chk({tag, ".de"},        16'(de), 16'(d));
        chk({tag, ".halted"},    16'(halted), 16'(hl));
        chk({tag, ".inst_out"},  inst_out, io);
        chk({tag, ".pc_out"},    pc_out, po);
    endtask

    task automatic drive(input logic s, input logic b, input logic h, input logic a,
                         input logic [15:0] inst, input logic [15:0] tgt);
        stall = s; bre = b; halt_req = h; imem_ack = a; inst_in = inst; br_target = tgt;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Reset is released 1 time unit after an edge, so the following cycle is BOOT.
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //               stl bre hlt ack inst      tgt       req addr      de hlt inst_out  pc_out
        vecs[0]  = mk(0, 0, 0, 1, 16'hAAAA, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000); // BOOT, ack ignored
        vecs[1]  = mk(0, 0, 0, 1, 16'h1000, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 0, 0, 1, 16'hFFFF, 16'h0000, 0, 16'h0000, 1, 0, 16'h1000, 16'h0000);
        vecs[3]  = mk(0, 0, 0, 1, 16'h1001, 16'h0000, 1, 16'h0001, 0, 0, 16'h1000, 16'h0000);
        vecs[4]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0001, 1, 0, 16'h1001, 16'h0001);
        vecs[5]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 0, 0, 16'h1001, 16'h0001);
        vecs[6]  = mk(0, 1, 0, 0, 16'h0000, 16'h7777, 1, 16'h0002, 0, 0, 16'h1001, 16'h0001); // bre in FETCH
        vecs[7]  = mk(0, 0, 0, 1, 16'h1002, 16'h0000, 1, 16'h0002, 0, 0, 16'h1001, 16'h0001);
        vecs[8]  = mk(0, 1, 0, 0, 16'h0000, 16'h1234, 0, 16'h0002, 1, 0, 16'h1002, 16'h0002);
        vecs[9]  = mk(0, 0, 0, 1, 16'h2000, 16'h0000, 1, 16'h1234, 0, 0, 16'h1002, 16'h0002);
        vecs[10] = mk(1, 1, 0, 0, 16'h0000, 16'h5555, 0, 16'h1234, 0, 0, 16'h2000, 16'h1234); // stall
        vecs[11] = mk(1, 1, 0, 0, 16'h0000, 16'h5555, 0, 16'h1234, 0, 0, 16'h2000, 16'h1234);
        vecs[12] = mk(0, 1, 0, 0, 16'h0000, 16'h5555, 0, 16'h1234, 1, 0, 16'h2000, 16'h1234);
        vecs[13] = mk(0, 1, 0, 1, 16'h3000, 16'hFFFF, 1, 16'h5555, 0, 0, 16'h2000, 16'h1234);
        vecs[14] = mk(0, 1, 0, 0, 16'h0000, 16'hFFFF, 0, 16'h5555, 1, 0, 16'h3000, 16'h5555);
        vecs[15] = mk(0, 0, 0, 1, 16'h4000, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h3000, 16'h5555);
        vecs[16] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'hFFFF, 1, 0, 16'h4000, 16'hFFFF); // wrap
        vecs[17] = mk(0, 0, 0, 1, 16'h5000, 16'h0000, 1, 16'h0000, 0, 0, 16'h4000, 16'hFFFF);
        vecs[18] = mk(0, 1, 0, 0, 16'h0000, 16'h0010, 0, 16'h0000, 1, 0, 16'h5000, 16'h0000);
        vecs[19] = mk(0, 0, 0, 1, 16'h6000, 16'h0000, 1, 16'h0010, 0, 0, 16'h5000, 16'h0000);
        vecs[20] = mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0010, 1, 0, 16'h6000, 16'h0010); // halt
        vecs[21] = mk(0, 0, 0, 1, 16'h7777, 16'h0000, 0, 16'h0011, 0, 1, 16'h6000, 16'h0010);
        vecs[22] = mk(0, 1, 0, 1, 16'h7777, 16'h9999, 0, 16'h0011, 0, 1, 16'h6000, 16'h0010);
        vecs[23] = mk(0, 1, 1, 1, 16'h7777, 16'h9999, 0, 16'h0011, 0, 1, 16'h6000, 16'h0010);

        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].bre, vecs[i].halt_req, vecs[i].ack,
                  vecs[i].inst, vecs[i].tgt);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_de,
                    vecs[i].exp_halted, vecs[i].exp_inst, vecs[i].exp_pc);
            next_cycle();
        end

        // Delayed ack at pc=0005: request held four cycles, single de pulse.
        do_reset();
        drive(0, 0, 0, 1, 16'h1111, 16'h0000); next_cycle();          // BOOT
        drive(0, 0, 0, 1, 16'h1111, 16'h0000); next_cycle();          // FETCH 0000
        drive(0, 1, 0, 0, 16'h0000, 16'h0005); next_cycle();          // EXEC -> 0005
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(0, 0, 0, 0, 16'hDEAD, 16'h0000);
            else       drive(0, 0, 0, 1, 16'h2222, 16'h0000);
            #1;
            chk_all($sformatf("wait%0d", i), 1'b1, 16'h0005, 1'b0, 1'b0, 16'h1111, 16'h0000);
            next_cycle();
        end
        drive(0, 0, 0, 0, 16'h0000, 16'h0000);
        #1;
        chk_all("ack_exec", 1'b0, 16'h0005, 1'b1, 1'b0, 16'h2222, 16'h0005);
        next_cycle();
        #1;
        chk_all("ack_next", 1'b1, 16'h0006, 1'b0, 1'b0, 16'h2222, 16'h0005);
        next_cycle();

        // Asynchronous reset during a FETCH wait, with a late ack held high.
        #1;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(0, 0, 0, 1, 16'h3333, 16'h0000);
        next_cycle();
        rst = 1'b0;
        #1;
        chk_all("rst_boot", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        next_cycle();
        drive(0, 0, 0, 1, 16'h4444, 16'h0000);
        #1;
        chk_all("rst_fetch", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        next_cycle();

        // Branch and halt together: pc takes the target, then HALT.
        drive(0, 1, 1, 0, 16'h0000, 16'hABCD);
        #1;
        chk_all("brhalt_exec", 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4444, 16'h0000);
        next_cycle();
        drive(0, 0, 0, 1, 16'h5555, 16'h0000);
        #1;
        chk_all("brhalt_halt", 1'b0, 16'hABCD, 1'b0, 1'b1, 16'h4444, 16'h0000);
        next_cycle();
        #1;
        chk_all("brhalt_stay", 1'b0, 16'hABCD, 1'b0, 1'b1, 16'h4444, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
